// File: rtl/regfile_pkg.sv
// Shared types for the multiport register file and its clear controller.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sweep controller: walks every entry once, emitting a zero-write per cycle.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | normal operation, writes accepted, waiting for clear_req
//  SWEEP | zeroing entry clr_addr each edge; writes dropped, reads zero
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                // clear_req is deliberately not looked at here: no restart mid-sweep
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == SWEEP);
    assign clr_en   = (state_q == SWEEP);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/multiport_register_file.sv
// Two-write / two-read register file with optional zero register, write
// forwarding, and a background clear sweep.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clear_req,
    output logic              busy,
    output logic              wr_ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr0_fire;
    logic              wr1_fire;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    assign wr_ready = !busy;

    // A write "fires" only if it will really land; this also gates forwarding.
    assign wr0_fire = we0 && wr_ready && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_fire = we1 && wr_ready && !((ZERO_REG != 0) && (waddr1 == '0));

    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else begin
            if (wr0_fire) mem_d[waddr0] = wdata0;
            if (wr1_fire) mem_d[waddr1] = wdata1;
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port 0
    always_comb begin
        rdata0 = mem_q[raddr0];
        if (BYPASS != 0) begin
            if (wr0_fire && (waddr0 == raddr0)) rdata0 = wdata0;
            if (wr1_fire && (waddr1 == raddr0)) rdata0 = wdata1;
        end
        if ((ZERO_REG != 0) && (raddr0 == '0)) rdata0 = '0;
        if (busy || reset) rdata0 = '0;
    end

    // Read port 1
    always_comb begin
        rdata1 = mem_q[raddr1];
        if (BYPASS != 0) begin
            if (wr0_fire && (waddr0 == raddr1)) rdata1 = wdata0;
            if (wr1_fire && (waddr1 == raddr1)) rdata1 = wdata1;
        end
        if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
        if (busy || reset) rdata1 = '0;
    end

endmodule
